// File: rtl/io_bus_arbiter.sv
// Shares the AVR I/O register bus between the CPU core and a secondary master (DMA/debug).
// The CPU has priority; a starved secondary access is forced through with a one-cycle core stall.
module io_bus_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] cpu_adr_i,
  input  logic [7:0] cpu_data_i,
  input  logic       cpu_re_i,
  input  logic       cpu_we_i,
  input  logic       cpu_ena_i,
  output logic [7:0] cpu_data_o,
  output logic       cpu_sel_o,
  output logic       cpu_stall_o,
  input  logic       dma_req_i,
  input  logic [5:0] dma_adr_i,
  input  logic [7:0] dma_data_i,
  input  logic       dma_we_i,
  output logic       dma_ack_o,
  output logic [7:0] dma_data_o,
  output logic       dma_hit_o,
  output logic [5:0] dev_adr_o,
  output logic [7:0] dev_data_o,
  output logic       dev_re_o,
  output logic       dev_we_o,
  output logic       dev_ena_o,
  input  logic [7:0] dev_data_i,
  input  logic       dev_sel_i
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t     state, state_nxt;
  logic [5:0] dma_adr_r;
  logic [7:0] dma_data_r;
  logic       dma_we_r;
  logic [7:0] wait_cnt;
  logic       free, force_acc, grant, latch;

  // Arbitration: CPU strobes mark the bus busy even when cpu_ena_i is low
  always_comb begin
    free      = !(cpu_re_i | cpu_we_i);
    force_acc = (wait_cnt == MAX_W);
    grant     = (state == WAIT) && (free || force_acc);
    latch     = (state == IDLE) && dma_req_i;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dma_req_i) state_nxt = WAIT;
      WAIT:    if (grant) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Completion side: ack pulse, wait counter and registered read result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt   <= 8'd0;
      dma_ack_o  <= 1'b0;
      dma_data_o <= 8'd0;
      dma_hit_o  <= 1'b0;
    end else begin
      dma_ack_o <= grant;
      if (latch) begin
        wait_cnt <= 8'd0;
      end else if ((state == WAIT) && !grant && (wait_cnt != MAX_W)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (grant && !dma_we_r) begin
        dma_data_o <= dev_data_i;
        dma_hit_o  <= dev_sel_i;
      end
    end
  end

  // Request capture: the master may change its inputs once the request is latched
  always_ff @(posedge clk_i) begin
    if (latch) begin
      dma_adr_r  <= dma_adr_i;
      dma_data_r <= dma_data_i;
      dma_we_r   <= dma_we_i;
    end
  end

  always_comb begin
    dev_adr_o  = cpu_adr_i;
    dev_data_o = cpu_data_i;
    dev_re_o   = cpu_re_i;
    dev_we_o   = cpu_we_i;
    dev_ena_o  = cpu_ena_i;
    if (grant) begin
      dev_adr_o  = dma_adr_r;
      dev_data_o = dma_data_r;
      dev_re_o   = !dma_we_r;
      dev_we_o   = dma_we_r;
      dev_ena_o  = 1'b1;
    end
  end

  assign cpu_data_o  = dev_data_i;
  assign cpu_sel_o   = dev_sel_i & !grant;
  assign cpu_stall_o = grant & !free;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: the driver queues expected secondary transactions,
// the monitor checks each one when dma_ack_o appears.
module tb_io_bus_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] cpu_adr_i;
  logic [7:0] cpu_data_i;
  logic       cpu_re_i, cpu_we_i, cpu_ena_i;
  logic [7:0] cpu_data_o;
  logic       cpu_sel_o, cpu_stall_o;
  logic       dma_req_i;
  logic [5:0] dma_adr_i;
  logic [7:0] dma_data_i;
  logic       dma_we_i;
  logic       dma_ack_o;
  logic [7:0] dma_data_o;
  logic       dma_hit_o;
  logic [5:0] dev_adr_o;
  logic [7:0] dev_data_o;
  logic       dev_re_o, dev_we_o, dev_ena_o;
  logic [7:0] dev_data_i;
  logic       dev_sel_i;

  io_bus_arbiter #(.MAX_WAIT(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_adr_i(cpu_adr_i), .cpu_data_i(cpu_data_i), .cpu_re_i(cpu_re_i),
    .cpu_we_i(cpu_we_i), .cpu_ena_i(cpu_ena_i),
    .cpu_data_o(cpu_data_o), .cpu_sel_o(cpu_sel_o), .cpu_stall_o(cpu_stall_o),
    .dma_req_i(dma_req_i), .dma_adr_i(dma_adr_i), .dma_data_i(dma_data_i),
    .dma_we_i(dma_we_i), .dma_ack_o(dma_ack_o), .dma_data_o(dma_data_o),
    .dma_hit_o(dma_hit_o),
    .dev_adr_o(dev_adr_o), .dev_data_o(dev_data_o), .dev_re_o(dev_re_o),
    .dev_we_o(dev_we_o), .dev_ena_o(dev_ena_o),
    .dev_data_i(dev_data_i), .dev_sel_i(dev_sel_i)
  );

  always #5 clk_i = ~clk_i;

  // Two readable device registers: 0x16 -> 0x3C, 0x20 -> 0x81
  always_comb begin
    dev_sel_i  = 1'b0;
    dev_data_i = 8'h00;
    if (dev_re_o && dev_ena_o) begin
      if (dev_adr_o == 6'h16) begin
        dev_sel_i  = 1'b1;
        dev_data_i = 8'h3C;
      end else if (dev_adr_o == 6'h20) begin
        dev_sel_i  = 1'b1;
        dev_data_i = 8'h81;
      end
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    logic [5:0]  adr;
    logic [7:0]  wdata;
    logic        we;
    logic        stall;
    logic [7:0]  rdata;
    logic        hit;
    int          id;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input int unsigned c, input logic [5:0] adr, input logic [7:0] wdata,
                      input logic we, input logic stall, input logic [7:0] rdata,
                      input logic hit, input int id);
    exp_t e;
    e.cyc = c; e.adr = adr; e.wdata = wdata; e.we = we; e.stall = stall;
    e.rdata = rdata; e.hit = hit; e.id = id;
    exp_q.push_back(e);
  endtask

  // Monitor: snapshot of the previous cycle is the grant cycle when an ack shows up
  logic [5:0] p_adr;
  logic [7:0] p_wdata;
  logic       p_re, p_we, p_ena, p_stall, p_sel;
  exp_t       m_e;

  always @(negedge clk_i) begin
    if (dma_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        m_e = exp_q.pop_front();
        chk($sformatf("t%0d_ack_cycle", m_e.id), m_e.cyc, cyc);
        chk($sformatf("t%0d_grant_bus", m_e.id),
            {p_adr, p_wdata, p_we, p_re, p_ena},
            {m_e.adr, m_e.wdata, m_e.we, !m_e.we, 1'b1});
        chk($sformatf("t%0d_grant_stall", m_e.id), p_stall, m_e.stall);
        chk($sformatf("t%0d_grant_cpu_sel", m_e.id), p_sel, 1'b0);
        chk($sformatf("t%0d_rdata", m_e.id), dma_data_o, m_e.rdata);
        chk($sformatf("t%0d_hit", m_e.id), dma_hit_o, m_e.hit);
      end
    end
    p_adr = dev_adr_o; p_wdata = dev_data_o; p_re = dev_re_o; p_we = dev_we_o;
    p_ena = dev_ena_o; p_stall = cpu_stall_o; p_sel = cpu_sel_o;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Waits for the ack pulse, checks the CPU bus is passed through in that cycle,
  // returns just after the edge that ends the ACK cycle.
  task automatic wait_ack(input string name);
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 40) begin
      @(negedge clk_i);
      if (dma_ack_o === 1'b1) begin
        got = 1'b1;
        chk({name, "_ack_passthru"},
            {dev_adr_o, dev_re_o, dev_we_o, cpu_stall_o},
            {cpu_adr_i, cpu_re_i, cpu_we_i, 1'b0});
      end
      n++;
    end
    if (!got) chk({name, "_ack_timeout"}, 32'd0, 32'd1);
    step();
  endtask

  int unsigned c0;

  initial begin
    rst_i = 1'b1;
    cpu_adr_i = 6'h05; cpu_data_i = 8'h00; cpu_re_i = 1'b0; cpu_we_i = 1'b0; cpu_ena_i = 1'b1;
    dma_req_i = 1'b0; dma_adr_i = 6'h00; dma_data_i = 8'h00; dma_we_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_ack", dma_ack_o, 1'b0);
    chk("reset_rdata", dma_data_o, 8'h00);
    chk("reset_hit", dma_hit_o, 1'b0);
    chk("reset_stall", cpu_stall_o, 1'b0);
    step();

    // T1: idle CPU, DMA write 0x18 <= 0xA5
    c0 = cyc;
    dma_req_i = 1'b1; dma_adr_i = 6'h18; dma_data_i = 8'hA5; dma_we_i = 1'b1;
    push(c0 + 2, 6'h18, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1);
    @(negedge clk_i);
    chk("t1_latch_no_access", {dev_adr_o, dev_we_o}, {6'h05, 1'b0});
    wait_ack("t1");
    dma_req_i = 1'b0;
    step();

    // T2: mapped read then unmapped read
    c0 = cyc;
    dma_req_i = 1'b1; dma_adr_i = 6'h16; dma_data_i = 8'h00; dma_we_i = 1'b0;
    push(c0 + 2, 6'h16, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1, 2);
    wait_ack("t2a");
    dma_req_i = 1'b0;
    step();
    c0 = cyc;
    dma_req_i = 1'b1; dma_adr_i = 6'h2A;
    push(c0 + 2, 6'h2A, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3);
    wait_ack("t2b");
    dma_req_i = 1'b0;
    step();

    // T3: CPU reads every cycle, access forced on the 16th WAIT cycle
    c0 = cyc;
    cpu_re_i = 1'b1; cpu_adr_i = 6'h20;
    dma_req_i = 1'b1; dma_adr_i = 6'h10; dma_data_i = 8'h5A; dma_we_i = 1'b1;
    push(c0 + 17, 6'h10, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 4);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      chk($sformatf("t3_cpu_passthru_c%0d", i),
          {dev_adr_o, dev_re_o, dev_we_o, cpu_sel_o, cpu_stall_o},
          {6'h20, 1'b1, 1'b0, 1'b1, 1'b0});
      step();
    end
    wait_ack("t3");
    dma_req_i = 1'b0; cpu_re_i = 1'b0; cpu_adr_i = 6'h05;
    step();

    // T4: CPU busy for WAIT cycles 1..3, granted in WAIT cycle 4
    c0 = cyc;
    dma_req_i = 1'b1; dma_adr_i = 6'h20; dma_data_i = 8'h00; dma_we_i = 1'b0;
    push(c0 + 5, 6'h20, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1, 5);
    step();
    cpu_re_i = 1'b1;
    step(); step(); step();
    cpu_re_i = 1'b0;
    wait_ack("t4");
    dma_req_i = 1'b0;
    step();

    // T5: reset in WAIT with wait_cnt=7, request re-accepted afterwards
    c0 = cyc;
    cpu_re_i = 1'b1; cpu_adr_i = 6'h05;
    dma_req_i = 1'b1; dma_adr_i = 6'h16; dma_data_i = 8'h00; dma_we_i = 1'b0;
    repeat (8) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; cpu_re_i = 1'b0;
    push(cyc + 2, 6'h16, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1, 6);
    @(negedge clk_i);
    chk("t5_post_reset_ack", dma_ack_o, 1'b0);
    chk("t5_post_reset_rdata", dma_data_o, 8'h00);
    chk("t5_post_reset_hit", dma_hit_o, 1'b0);
    chk("t5_post_reset_bus",
        {dev_adr_o, dev_data_o, dev_re_o, dev_we_o, dev_ena_o},
        {cpu_adr_i, cpu_data_i, cpu_re_i, cpu_we_i, cpu_ena_i});
    wait_ack("t5");
    dma_req_i = 1'b0;
    step();

    // T6: request held high, back-to-back writes at 3-cycle spacing
    dma_req_i = 1'b1; dma_we_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dma_adr_i  = 6'(k + 1);
      dma_data_i = 8'(8'h11 * (k + 1));
      push(cyc + 2, 6'(k + 1), 8'(8'h11 * (k + 1)), 1'b1, 1'b0, 8'h3C, 1'b1, 7 + k);
      step();
      dma_adr_i = 6'h3F; dma_data_i = 8'hFF;
      wait_ack($sformatf("t6_%0d", k));
    end
    dma_req_i = 1'b0;
    repeat (4) step();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the AVR I/O register bus (6-bit address, 8-bit data) between the CPU core and a secondary master such as a DMA or debug engine.
- Sits between the core's I/O bus and the I/O devices (ports, timers, UART) and drives their adr/data/re/we/ena inputs.
- The CPU always has priority. A secondary access is inserted in a cycle where the CPU is not accessing the bus.
- If the secondary master has waited MAX_WAIT cycles, the block stalls the core for one cycle and forces its access through.

Parameters:
MAX_WAIT, 15, secondary wait cycles before a forced access; legal range 0..255.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active high
cpu_adr_i  in  6  CPU I/O address
cpu_data_i  in  8  CPU write data
cpu_re_i  in  1  CPU read strobe
cpu_we_i  in  1  CPU write strobe
cpu_ena_i  in  1  CPU core enable
cpu_data_o  out  8  read data returned to CPU
cpu_sel_o  out  1  a device responded to the CPU read
cpu_stall_o  out  1  core must hold and repeat its current cycle
dma_req_i  in  1  secondary request, level; held until dma_ack_o
dma_adr_i  in  6  secondary address
dma_data_i  in  8  secondary write data
dma_we_i  in  1  1 = write, 0 = read
dma_ack_o  out  1  one-cycle completion pulse
dma_data_o  out  8  registered read data
dma_hit_o  out  1  registered: a device responded to the read
dev_adr_o  out  6  shared bus address
dev_data_o  out  8  shared bus write data
dev_re_o  out  1  shared bus read strobe
dev_we_o  out  1  shared bus write strobe
dev_ena_o  out  1  shared bus enable
dev_data_i  in  8  OR-combined device read data
dev_sel_i  in  1  OR-combined device selected_o

Behaviour:
- States: IDLE, WAIT, ACK. Registers: dma_adr_r, dma_data_r, dma_we_r, wait_cnt (8 bit), dma_data_o, dma_hit_o, dma_ack_o.
- Reset (rst_i=1 at a rising edge):
  - State goes to IDLE.
  - wait_cnt, dma_ack_o, dma_data_o and dma_hit_o are cleared to 0.
  - A request in flight is dropped. The master still holds dma_req_i, so the request is re-accepted after reset.
- IDLE:
  - When dma_req_i=1, latch dma_adr_i, dma_data_i and dma_we_i, clear wait_cnt, and go to WAIT.
  - No bus access happens in the latch cycle.
- WAIT: free = !(cpu_re_i | cpu_we_i); force = (wait_cnt == MAX_WAIT).
  - grant = free | force, combinational.
  - If grant: perform the secondary access this cycle. At the clock edge, dma_data_o <= dev_data_i and dma_hit_o <= dev_sel_i for reads (both unchanged for writes). Go to ACK.
  - Else: wait_cnt <= wait_cnt + 1 and stay in WAIT.
  - wait_cnt saturates at MAX_WAIT and never wraps.
- ACK: dma_ack_o=1 for exactly one cycle, then go to IDLE.
  - Minimum spacing is 3 cycles per secondary access.
  - If dma_req_i is still high in IDLE, it is treated as a new request.
- Bus mux (combinational):
  - While grant is active in WAIT:
    - dev_adr_o = dma_adr_r, dev_data_o = dma_data_r
    - dev_we_o = dma_we_r, dev_re_o = !dma_we_r
    - dev_ena_o = 1
  - Otherwise: dev_* are cpu_adr_i, cpu_data_i, cpu_re_i, cpu_we_i, cpu_ena_i unchanged.
- cpu_data_o = dev_data_i.
- cpu_sel_o = dev_sel_i & !grant.
- cpu_stall_o = grant & !free, i.e. only on a forced access that collides with a CPU access. The CPU access is not presented that cycle; the core repeats it next cycle, when it wins.
- MAX_WAIT = 0: the first WAIT cycle always grants, stalling the CPU if it is busy.
- A CPU access with cpu_ena_i=0 still counts as busy.
- Combinational path from cpu_*_i to dev_*_o has no added latency.

Test Plan:
1. Idle CPU, DMA write adr=0x18 data=0xA5 → WAIT is entered one cycle after req and grants immediately with dev_we_o=1, dev_adr_o=0x18, dev_data_o=0xA5, cpu_stall_o=0; dma_ack_o is high exactly 1 cycle later.
2. Idle CPU, DMA read adr=0x16 with device returning 0x3C and sel=1 → dma_data_o=0x3C, dma_hit_o=1 when dma_ack_o=1. Repeat with an unmapped address → dma_hit_o=0.
3. CPU reads every cycle, MAX_WAIT=15 → the DMA access is forced on the 16th WAIT cycle with cpu_stall_o=1 for 1 cycle, cpu_sel_o=0 that cycle, and the CPU bus is passed through in every other cycle.
4. CPU busy 3 cycles then idle → the DMA access is granted in WAIT cycle 4 with no stall, and wait_cnt never reaches MAX_WAIT.
5. rst_i asserted while in WAIT (wait_cnt=7) → the next cycle shows IDLE, ack=0, dma_data_o=0, dev_* equal to the CPU inputs; with req still high the request is re-latched and completes.
6. dma_req_i held high continuously with the CPU idle → acks occur at 3-cycle spacing, and each access uses the newly latched dma_adr_i/dma_data_i.
